tick_divider: RTL and testbench
===============================

// Module: tick_divider
// PURPOSE
//  Programmable clock-enable generator; parametrised successor to the fixed-ratio divider.
//  Emits a 1-cycle tick every div_reg cycles of clk_in; run/pause via start.
//  Supports periodic and one-shot modes, runtime reload of the divide ratio,
//    and a wrapping tick tally.
//  Drives the countdown/display timebase from the board clock.
// PARAMETERS
//  WIDTH        24        width of divide counter and divide register
//  DEFAULT_DIV  10000000  divide ratio after reset; must be >=1 and < 2**WIDTH
//  TC_WIDTH     8         width of tick_count tally
// PORTS
//  clk_in      in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-high reset
//  start       in   1         level run enable; high=run, low=pause/idle
//  clear       in   1         synchronous restart: counter, tally, done cleared
//  div_load    in   1         1-cycle strobe: capture div_value into div_reg
//  div_value   in   WIDTH     new divide ratio; 0 is clamped to 1
//  oneshot     in   1         mode, sampled on IDLE->RUN: 1=single tick, 0=periodic
//  tick        out  1         registered 1-cycle pulse at each terminal count
//  running     out  1         high while state==RUN
//  done        out  1         one-shot complete; high while state==DONE
//  count       out  WIDTH     current counter value
//  tick_count  out  TC_WIDTH  ticks since reset/clear; wraps modulo 2**TC_WIDTH
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0, div_reg=DEFAULT_DIV, mode_reg=0;
//    tick=0, done=0, running=0, tick_count=0.
//  Priority each edge: reset > clear > div_load / state logic.
//  States:
//    IDLE : counter=0. start=1 -> RUN; mode_reg<=oneshot; counter stays 0 on that edge.
//    RUN  : start=0 -> PAUSE (counter held, no increment that edge).
//           Else terminal test: counter >= div_reg-1 -> counter<=0, tick<=1, tick_count+1;
//             then mode_reg=1 -> DONE.
//           Otherwise counter<=counter+1, tick<=0.
//    PAUSE: counter and tally held, tick=0. start=1 -> RUN, resuming from held count.
//    DONE : tick=0, counter=0. start=0 -> IDLE; start stays 1 -> remain DONE.
//  Timing:
//    - First tick is high in the cycle that starts div_reg cycles after entry to RUN.
//    - Subsequent ticks are exactly div_reg cycles apart.
//    - div_reg=1 -> tick every RUN cycle.
//  tick is never high for 2 consecutive cycles unless div_reg=1.
//  tick is 0 in every cycle outside RUN-terminal.
//  div_load:
//    - Effective from the next edge; a terminal on the same edge uses the old div_reg.
//    - A new div_reg <= current counter forces terminal on the next RUN edge
//      (the >= compare; no 2**WIDTH overrun).
//  clear:
//    - counter=0, tick=0, tick_count=0, state=IDLE.
//    - div_reg is kept; clear+div_load on the same edge: load still applies.
//    - Held start re-enters RUN on the following edge.
//  Reset mid-count: all outputs take reset values immediately (async), independent of clk_in.
//  Arithmetic: counter and tick_count are unsigned and wrap naturally; no saturation.
// TESTING
//  1. div_load 4, start=1 held, oneshot=0 -> tick high every 4th cycle; first one 4 cycles
//     after running rises; tick_count 1,2,3.
//  2. Pause: start low after count=2 for 5 cycles, then high -> count holds at 2;
//     next tick 2 cycles after resume.
//  3. oneshot=1, div 3 -> exactly one tick, done=1, running=0.
//     Drop start -> done=0, IDLE; raise start -> new single tick.
//  4. Running at div 10 with count=7: load 5 -> tick on next edge.
//     Load 0 -> div_reg=1, tick every cycle.
//  5. TC_WIDTH=8, 256 ticks at div 1 -> tick_count wraps 255->0.
//     clear mid-run -> count=0, tick_count=0, restart.
//  6. Assert reset async between edges while running -> all outputs 0
//     and div_reg=DEFAULT_DIV on release.

Source files
------------

// File: rtl/tick_divider_if.sv
// Control/status bundle for tick_divider: run/mode/ratio controls in, tick and tallies out.
interface tick_divider_if #(
  parameter int WIDTH    = 24,
  parameter int TC_WIDTH = 8
);
  logic                start;
  logic                clear;
  logic                div_load;
  logic [WIDTH-1:0]    div_value;
  logic                oneshot;
  logic                tick;
  logic                running;
  logic                done;
  logic [WIDTH-1:0]    count;
  logic [TC_WIDTH-1:0] tick_count;

  modport master (
    output start, clear, div_load, div_value, oneshot,
    input  tick, running, done, count, tick_count
  );

  modport slave (
    input  start, clear, div_load, div_value, oneshot,
    output tick, running, done, count, tick_count
  );
endinterface

// File: rtl/tick_divider.sv
// Programmable clock-enable generator: one-cycle tick every div_reg cycles,
// periodic or one-shot, with runtime ratio reload and a wrapping tick tally.
module tick_divider #(
  parameter int          WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 10000000,
  parameter int          TC_WIDTH    = 8
) (
  input  logic          clk_in,
  input  logic          reset,
  tick_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t              state, state_d;
  logic [WIDTH-1:0]    counter, counter_d, div_reg;
  logic [TC_WIDTH-1:0] tc, tc_d;
  logic                mode_reg, mode_d;
  logic                tick_r, tick_d;
  logic                terminal;

  // >= rather than == so a ratio shrunk below the live count terminates at once
  assign terminal = (counter >= (div_reg - WIDTH'(1)));

  always_comb begin
    state_d   = state;
    counter_d = counter;
    tc_d      = tc;
    mode_d    = mode_reg;
    tick_d    = 1'b0;
    if (bus.clear) begin
      state_d   = IDLE;
      counter_d = '0;
      tc_d      = '0;
    end else begin
      case (state)
        IDLE: begin
          counter_d = '0;
          if (bus.start) begin
            state_d = RUN;
            mode_d  = bus.oneshot;
          end
        end
        RUN: begin
          if (!bus.start) begin
            state_d = PAUSE;
          end else if (terminal) begin
            counter_d = '0;
            tick_d    = 1'b1;
            tc_d      = tc + TC_WIDTH'(1);
            if (mode_reg) state_d = DONE;
          end else begin
            counter_d = counter + WIDTH'(1);
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        DONE: begin
          counter_d = '0;
          if (!bus.start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      tc       <= '0;
      mode_reg <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      state    <= state_d;
      counter  <= counter_d;
      tc       <= tc_d;
      mode_reg <= mode_d;
      tick_r   <= tick_d;
    end
  end

  // Ratio register sits outside the clear path: clear restarts, it does not reprogram
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)
      div_reg <= WIDTH'(DEFAULT_DIV);
    else if (bus.div_load)
      div_reg <= (bus.div_value == '0) ? WIDTH'(1) : bus.div_value;
  end

  assign bus.tick       = tick_r;
  assign bus.running    = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.count      = counter;
  assign bus.tick_count = tc;
endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider: cycle-by-cycle vector table plus hand sequences
// for tally wrap, clear mid-run and asynchronous reset.
module tb_tick_divider;
  localparam int W   = 8;
  localparam int TCW = 8;
  localparam int DEF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_divider_if #(.WIDTH(W), .TC_WIDTH(TCW)) bus ();

  tick_divider #(.WIDTH(W), .DEFAULT_DIV(DEF), .TC_WIDTH(TCW)) dut (
    .clk_in (clk),
    .reset  (rst),
    .bus    (bus)
  );

  typedef struct {
    logic         st, clr, ld;
    logic [W-1:0] dv;
    logic         os;
    logic         tk, run, dn;
    logic [W-1:0] cnt;
    logic [TCW-1:0] tc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic st, clr, ld, input int dv, input logic os,
                     input logic tk, run, dn, input int cnt, tc);
    vec_t v;
    v.st = st; v.clr = clr; v.ld = ld; v.dv = W'(dv); v.os = os;
    v.tk = tk; v.run = run; v.dn = dn; v.cnt = W'(cnt); v.tc = TCW'(tc);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, clr, ld, input int dv, input logic os);
    bus.start = st; bus.clear = clr; bus.div_load = ld;
    bus.div_value = W'(dv); bus.oneshot = os;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic tk, run, dn, input int cnt, tc);
    check({tag, ".tick"},       int'(bus.tick),       int'(tk));
    check({tag, ".running"},    int'(bus.running),    int'(run));
    check({tag, ".done"},       int'(bus.done),       int'(dn));
    check({tag, ".count"},      int'(bus.count),      cnt);
    check({tag, ".tick_count"}, int'(bus.tick_count), tc);
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0, 0);

    // periodic at ratio 4
    add(0,0,1,4,0, 0,0,0,0,0);
    add(1,0,0,0,0, 0,1,0,0,0);
    add(1,0,0,0,0, 0,1,0,1,0);
    add(1,0,0,0,0, 0,1,0,2,0);
    add(1,0,0,0,0, 0,1,0,3,0);
    add(1,0,0,0,0, 1,1,0,0,1);
    add(1,0,0,0,0, 0,1,0,1,1);
    add(1,0,0,0,0, 0,1,0,2,1);
    add(1,0,0,0,0, 0,1,0,3,1);
    add(1,0,0,0,0, 1,1,0,0,2);
    add(1,0,0,0,0, 0,1,0,1,2);
    add(1,0,0,0,0, 0,1,0,2,2);
    // pause at count 2 for five cycles, then resume
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0,0,2,2);
    add(1,0,0,0,0, 0,1,0,2,2);
    add(1,0,0,0,0, 0,1,0,3,2);
    add(1,0,0,0,0, 1,1,0,0,3);
    add(0,0,0,0,0, 0,0,0,0,3);
    add(0,1,0,0,0, 0,0,0,0,0);
    // one-shot at ratio 3, twice
    add(0,0,1,3,0, 0,0,0,0,0);
    add(1,0,0,0,1, 0,1,0,0,0);
    add(1,0,0,0,1, 0,1,0,1,0);
    add(1,0,0,0,1, 0,1,0,2,0);
    add(1,0,0,0,1, 1,0,1,0,1);
    add(1,0,0,0,1, 0,0,1,0,1);
    add(0,0,0,0,1, 0,0,0,0,1);
    add(1,0,0,0,1, 0,1,0,0,1);
    add(1,0,0,0,1, 0,1,0,1,1);
    add(1,0,0,0,1, 0,1,0,2,1);
    add(1,0,0,0,1, 1,0,1,0,2);
    add(0,0,0,0,0, 0,0,0,0,2);
    // ratio 10, shrink to 5 at count 7, then load 0 (clamps to 1)
    add(0,0,1,10,0, 0,0,0,0,2);
    add(1,0,0,0,0,  0,1,0,0,2);
    for (int i = 1; i <= 7; i++) add(1,0,0,0,0, 0,1,0,i,2);
    add(1,0,1,5,0, 0,1,0,8,2);
    add(1,0,0,0,0, 1,1,0,0,3);
    add(1,0,1,0,0, 0,1,0,1,3);
    add(1,0,0,0,0, 1,1,0,0,4);
    add(1,0,0,0,0, 1,1,0,0,5);
    add(1,0,0,0,0, 1,1,0,0,6);

    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].clr, vecs[i].ld, int'(vecs[i].dv), vecs[i].os);
      cyc();
      check_all($sformatf("vec%0d", i), vecs[i].tk, vecs[i].run, vecs[i].dn,
                int'(vecs[i].cnt), int'(vecs[i].tc));
    end

    // tally wrap at ratio 1
    drive(1, 0, 0, 0, 0);
    repeat (249) cyc();
    check("wrap.pre_tc",  int'(bus.tick_count), 255);
    check("wrap.pre_tk",  int'(bus.tick), 1);
    cyc();
    check("wrap.tc",      int'(bus.tick_count), 0);
    check("wrap.tk",      int'(bus.tick), 1);

    // clear mid-run with start held
    drive(1, 1, 0, 0, 0);
    cyc();
    check_all("clear", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    cyc();
    check_all("clear.rerun", 0, 1, 0, 0, 0);
    cyc();
    check_all("clear.tick", 1, 1, 0, 0, 1);

    // async reset between edges while counting at ratio 8
    drive(1, 0, 1, 8, 0);
    cyc();
    drive(1, 0, 0, 0, 0);
    repeat (3) cyc();
    check("pre_rst.count", int'(bus.count), 3);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    cyc();
    check("post_rst.running", int'(bus.running), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n++;
      if (bus.tick) break;
    end
    check("post_rst.default_period", n, DEF);
    check("post_rst.tc", int'(bus.tick_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
